// File: rtl/snake_pkg.sv
// Shared snake-game definitions: cell encoding, screen/grid geometry and
// the RAM arbiter state type used by the grid memory arbiter slice.
package snake_pkg;

    localparam int CELL_SHIFT = 4;
    localparam int GRID_W     = 40;
    localparam int GRID_H     = 30;
    localparam int H_ACTIVE   = 640;
    localparam int V_ACTIVE   = 480;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        SNAKE = 2'd1,
        FOOD  = 2'd2,
        WALL  = 2'd3
    } cell_t;

    typedef enum logic {
        RENDER = 1'b0,
        GAME   = 1'b1
    } arb_state_t;

endpackage

// File: rtl/grid_mem_arbiter_if.sv
// Game-engine access channel plus grid RAM bus of the arbiter.
// slave: arbiter side. master: game engine / RAM / bench side.
interface grid_mem_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 2
);
    logic              game_req;
    logic              game_en;
    logic              game_we;
    logic [ADDR_W-1:0] game_addr;
    logic [DATA_W-1:0] game_wdata;
    logic              game_done;
    logic              game_gnt;
    logic [DATA_W-1:0] game_rdata;
    logic              game_rvalid;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  game_req, game_en, game_we, game_addr, game_wdata,
        input  game_done, mem_rdata,
        output game_gnt, game_rdata, game_rvalid,
        output mem_addr, mem_we, mem_wdata
    );

    modport master (
        output game_req, game_en, game_we, game_addr, game_wdata,
        output game_done, mem_rdata,
        input  game_gnt, game_rdata, game_rvalid,
        input  mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/frame_step_timer.sv
// Detects the start of vertical blanking, counts frames and emits a
// one-cycle step_tick every STEP_FRAMES frames.
// Ports: clk, rst (sync, active high), vblank in; step_tick out.
module frame_step_timer #(
    parameter int STEP_FRAMES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic vblank,
    output logic step_tick
);
    localparam int CW = $clog2(STEP_FRAMES + 1);
    localparam logic [CW-1:0] LAST = CW'(STEP_FRAMES - 1);

    logic          vblank_q;
    logic [CW-1:0] frame_cnt;
    logic          vblank_start;

    assign vblank_start = vblank & ~vblank_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vblank_q  <= 1'b0;
            frame_cnt <= '0;
            step_tick <= 1'b0;
        end else begin
            vblank_q  <= vblank;
            step_tick <= 1'b0;
            if (vblank_start) begin
                if (frame_cnt == LAST) begin
                    frame_cnt <= '0;
                    step_tick <= 1'b1;
                end else begin
                    frame_cnt <= frame_cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: rtl/grid_mem_arbiter.sv
// Shares the single-port grid RAM: VGA cell reads during active video,
// exclusive game-engine access during vertical blanking, game step tick.
// Ports: clk, rst (sync, active high); r_pixel/c_pixel/video_on from vga;
// step_tick, overrun_err, pix_cell, pix_valid out; bus carries the game
// channel and the RAM bus (mem_rdata sampled the cycle after mem_addr).
module grid_mem_arbiter #(
    parameter int CELL_SHIFT  = snake_pkg::CELL_SHIFT,
    parameter int GRID_W      = snake_pkg::GRID_W,
    parameter int GRID_H      = snake_pkg::GRID_H,
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 2,
    parameter int V_ACTIVE    = snake_pkg::V_ACTIVE,
    parameter int STEP_FRAMES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        r_pixel,
    input  logic [9:0]        c_pixel,
    input  logic              video_on,
    output logic              step_tick,
    output logic              overrun_err,
    output logic [DATA_W-1:0] pix_cell,
    output logic              pix_valid,
    grid_mem_arbiter_if.slave bus
);
    import snake_pkg::*;

    localparam logic [9:0] V_START = 10'(V_ACTIVE);
    localparam logic [9:0] ROWS    = 10'(GRID_H);
    localparam logic [9:0] COLS    = 10'(GRID_W);

    // Constant multiply unrolled into shifted adds of the set bits of GRID_W.
    function automatic logic [ADDR_W-1:0] times_grid_w(
        input logic [ADDR_W-1:0] v
    );
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < ADDR_W && i < 32; i++) begin
            if (GRID_W[i]) acc = acc + (v << i);
        end
        return acc;
    endfunction

    logic              vblank;
    logic [9:0]        row;
    logic [9:0]        col;
    logic              in_grid;
    logic [ADDR_W-1:0] render_addr;
    logic              accept;

    arb_state_t state;
    logic       rd_pend;
    logic       game_src;
    logic       von_q;

    assign vblank  = (r_pixel >= V_START);
    assign row     = r_pixel >> CELL_SHIFT;
    assign col     = c_pixel >> CELL_SHIFT;
    assign in_grid = video_on & (row < ROWS) & (col < COLS);

    assign render_addr = in_grid
        ? times_grid_w(ADDR_W'(row)) + ADDR_W'(col)
        : '0;

    assign accept = (state == GAME) & bus.game_en;

    frame_step_timer #(
        .STEP_FRAMES(STEP_FRAMES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .vblank    (vblank),
        .step_tick (step_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= RENDER;
            bus.game_gnt    <= 1'b0;
            overrun_err     <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_we      <= 1'b0;
            bus.mem_wdata   <= '0;
            rd_pend         <= 1'b0;
            game_src        <= 1'b0;
            bus.game_rvalid <= 1'b0;
            bus.game_rdata  <= '0;
            von_q           <= 1'b0;
            pix_valid       <= 1'b0;
            pix_cell        <= '0;
        end else begin
            unique case (state)
                RENDER: begin
                    if (vblank & bus.game_req) begin
                        state        <= GAME;
                        bus.game_gnt <= 1'b1;
                    end
                end
                GAME: begin
                    if (bus.game_done | ~bus.game_req | ~vblank) begin
                        state        <= RENDER;
                        bus.game_gnt <= 1'b0;
                        if (~vblank) overrun_err <= 1'b1;
                    end
                end
            endcase

            bus.mem_addr  <= accept ? bus.game_addr : render_addr;
            bus.mem_we    <= accept & bus.game_we;
            bus.mem_wdata <= accept ? bus.game_wdata : '0;

            // Tags travel with the address so the returning data is
            // steered to the game port or to the pixel path.
            rd_pend  <= accept & ~bus.game_we;
            game_src <= accept;

            bus.game_rvalid <= rd_pend;
            bus.game_rdata  <= rd_pend ? bus.mem_rdata : '0;

            von_q     <= video_on;
            pix_valid <= von_q;
            pix_cell  <= ((state == GAME) | game_src) ? '0 : bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_grid_mem_arbiter.sv
// Self-checking bench for grid_mem_arbiter: directed scenarios plus
// randomized traffic compared every cycle with a behavioural model.
module tb_grid_mem_arbiter;
    localparam int AW = 11;
    localparam int DW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [9:0]    r_pixel;
    logic [9:0]    c_pixel;
    logic          video_on;
    logic          step_tick;
    logic          overrun_err;
    logic [DW-1:0] pix_cell;
    logic          pix_valid;

    int checks = 0;
    int errors = 0;

    grid_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    grid_mem_arbiter #(
        .CELL_SHIFT(4), .GRID_W(40), .GRID_H(30), .ADDR_W(AW),
        .DATA_W(DW), .V_ACTIVE(480), .STEP_FRAMES(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .r_pixel     (r_pixel),
        .c_pixel     (c_pixel),
        .video_on    (video_on),
        .step_tick   (step_tick),
        .overrun_err (overrun_err),
        .pix_cell    (pix_cell),
        .pix_valid   (pix_valid),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int i);
        return DW'(((i * 3) ^ (i >> 7)) & 3);
    endfunction

    // Environment RAM driven by the DUT's bus (combinational read port).
    logic [DW-1:0] env_ram [0:2047];
    logic          env_init = 1'b0;
    assign bus.mem_rdata = env_ram[bus.mem_addr];

    always @(posedge clk) begin
        if (!env_init) begin
            for (int i = 0; i < 2048; i++) env_ram[i] <= init_val(i);
            env_init <= 1'b1;
        end else if (bus.mem_we) begin
            env_ram[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%0d required=%0d at %0t",
                         name, act, exp, $time);
        end
    endtask

    // Behavioural model: expected outputs per cycle from the rules.
    logic [DW-1:0] mdl_ram [0:2047];
    bit m_init = 0;
    bit cmp_en = 0;
    bit e_gnt, e_ovr, e_tick, e_we, e_rvalid, e_pv;
    int e_addr, e_wdata, e_rdata, e_pix;
    int frames;
    bit prev_vb, prev_acc, prev_rd, prev_von;

    always @(posedge clk) begin
        bit vb, acc;
        int cur_rd, n_addr;
        if (!m_init) begin
            for (int i = 0; i < 2048; i++) mdl_ram[i] = init_val(i);
            m_init = 1;
        end
        cur_rd = int'(mdl_ram[e_addr]);
        if (e_we) mdl_ram[e_addr] = DW'(e_wdata);
        if (rst) begin
            e_gnt = 0; e_ovr = 0; e_tick = 0; e_we = 0; e_rvalid = 0;
            e_pv = 0; e_addr = 0; e_wdata = 0; e_rdata = 0; e_pix = 0;
            frames = 0; prev_vb = 0; prev_acc = 0; prev_rd = 0;
            prev_von = 0;
        end else begin
            vb  = (int'(r_pixel) >= 480);
            acc = e_gnt && bus.game_en;
            if (acc) n_addr = int'(bus.game_addr);
            else if (video_on)
                n_addr = (int'(r_pixel) / 16) * 40 + int'(c_pixel) / 16;
            else n_addr = 0;
            e_pix    = (e_gnt || prev_acc) ? 0 : cur_rd;
            e_pv     = prev_von;
            e_rvalid = prev_rd;
            e_rdata  = prev_rd ? cur_rd : 0;
            e_tick   = vb && !prev_vb && frames == 7;
            if (vb && !prev_vb) frames = (frames + 1) % 8;
            if (e_gnt && !vb) e_ovr = 1;
            if (e_gnt) e_gnt = bus.game_req && !bus.game_done && vb;
            else       e_gnt = vb && bus.game_req;
            e_addr   = n_addr;
            e_we     = acc && bus.game_we;
            e_wdata  = acc ? int'(bus.game_wdata) : 0;
            prev_acc = acc;
            prev_rd  = acc && !bus.game_we;
            prev_von = video_on;
            prev_vb  = vb;
        end
        cmp_en = 1;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("game_gnt", 32'(bus.game_gnt), 32'(e_gnt));
            check("overrun_err", 32'(overrun_err), 32'(e_ovr));
            check("step_tick", 32'(step_tick), 32'(e_tick));
            check("mem_addr", 32'(bus.mem_addr), e_addr);
            check("mem_we", 32'(bus.mem_we), 32'(e_we));
            check("mem_wdata", 32'(bus.mem_wdata), e_wdata);
            check("game_rvalid", 32'(bus.game_rvalid), 32'(e_rvalid));
            check("game_rdata", 32'(bus.game_rdata), e_rdata);
            check("pix_valid", 32'(pix_valid), 32'(e_pv));
            check("pix_cell", 32'(pix_cell), e_pix);
        end
    end

    task automatic drive(input bit rs, input int r, input int c,
                         input bit v, input bit req, input bit en,
                         input bit we, input int a, input int wd,
                         input bit dn);
        @(posedge clk);
        #2;
        rst = rs;
        r_pixel = 10'(r);
        c_pixel = 10'(c);
        video_on = v;
        bus.game_req = req;
        bus.game_en = en;
        bus.game_we = we;
        bus.game_addr = AW'(a);
        bus.game_wdata = DW'(wd);
        bus.game_done = dn;
    endtask

    initial begin
        int ticks [1:8];
        int r, c, seg, req;
        bit v;
        rst = 1; r_pixel = 490; c_pixel = 0; video_on = 0;
        bus.game_req = 1; bus.game_en = 0; bus.game_we = 0;
        bus.game_addr = '0; bus.game_wdata = '0; bus.game_done = 0;

        // Reset with a pending request inside blanking.
        for (int i = 0; i < 3; i++) begin
            drive(1, 490, 0, 0, 1, 0, 0, 0, 0, 0);
            @(negedge clk);
            check("rst_gnt", 32'(bus.game_gnt), 0);
        end
        check("rst_mem_we", 32'(bus.mem_we), 0);
        check("rst_mem_addr", 32'(bus.mem_addr), 0);
        check("rst_ovr", 32'(overrun_err), 0);
        check("rst_tick", 32'(step_tick), 0);
        check("rst_pix_valid", 32'(pix_valid), 0);
        check("rst_rvalid", 32'(bus.game_rvalid), 0);

        // Render address and pixel pipeline.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 35, 100, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 35, 100, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("render_addr", 32'(bus.mem_addr), 86);
        check("model_addr", e_addr, 86);
        drive(0, 35, 100, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("pix_cell_86", 32'(pix_cell), 2);
        check("pix_valid_on", 32'(pix_valid), 1);

        // Eight frames, one row per cycle.
        for (int f = 1; f <= 8; f++) begin
            ticks[f] = 0;
            for (int rr = 0; rr < 525; rr++) begin
                c = $urandom_range(0, 639);
                drive(0, rr, c, rr < 480, 0, 0, 0, 0, 0, 0);
                @(negedge clk);
                if (step_tick) ticks[f]++;
                if (f == 8 && rr == 481)
                    check("tick_frame8", 32'(step_tick), 1);
            end
        end
        for (int f = 1; f <= 7; f++)
            check("ticks_early", ticks[f], 0);
        check("ticks_frame8", ticks[8], 1);

        // Grant in blanking, write, then read back.
        drive(0, 490, 0, 0, 1, 0, 0, 0, 0, 0);
        drive(0, 490, 0, 0, 1, 1, 1, 1199, 1, 0);
        @(negedge clk);
        check("gnt_rise", 32'(bus.game_gnt), 1);
        drive(0, 490, 0, 0, 1, 1, 1, 5, 3, 0);
        @(negedge clk);
        check("wr_we", 32'(bus.mem_we), 1);
        check("wr_addr", 32'(bus.mem_addr), 1199);
        check("wr_data", 32'(bus.mem_wdata), 1);
        drive(0, 490, 0, 0, 1, 1, 0, 5, 0, 0);
        drive(0, 490, 0, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rd_addr", 32'(bus.mem_addr), 5);
        check("rd_we", 32'(bus.mem_we), 0);
        drive(0, 490, 0, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rd_rvalid", 32'(bus.game_rvalid), 1);
        check("rd_rdata", 32'(bus.game_rdata), 3);
        check("model_rdata", e_rdata, 3);

        // Hold the grant past the end of blanking.
        drive(0, 524, 0, 0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 16, 1, 1, 1, 1, 77, 2, 0);
        @(negedge clk);
        check("ovr_gnt", 32'(bus.game_gnt), 0);
        check("ovr_set", 32'(overrun_err), 1);
        drive(0, 0, 32, 1, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("ovr_no_we", 32'(bus.mem_we), 0);
        for (int i = 0; i < 4; i++)
            drive(0, 1, 48, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("ovr_sticky", 32'(overrun_err), 1);

        // Request raised during active video is held off.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 100, 0, 0, 1, 0, 0, 0, 0, 0);
            @(negedge clk);
            check("holdoff_gnt", 32'(bus.game_gnt), 0);
        end
        drive(0, 480, 0, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("pre_gnt", 32'(bus.game_gnt), 0);
        drive(0, 481, 0, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("late_gnt", 32'(bus.game_gnt), 1);
        drive(0, 482, 0, 0, 1, 0, 0, 0, 0, 1);
        drive(0, 483, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("done_gnt", 32'(bus.game_gnt), 0);
        check("done_no_ovr", 32'(overrun_err), 0);

        // Randomized traffic.
        req = 0;
        r = 0;
        c = 0;
        seg = 0;
        for (int n = 0; n < 3000; n++) begin
            if (seg == 0) begin
                seg = $urandom_range(1, 12);
                if ($urandom_range(0, 2) == 0) r = $urandom_range(480, 524);
                else r = $urandom_range(0, 479);
            end
            seg--;
            c = $urandom_range(0, 799);
            v = (r < 480) && (c < 640);
            if ($urandom_range(0, 9) == 0) req = 1 - req;
            drive($urandom_range(0, 149) == 0, r, c, v, req[0],
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2047), $urandom_range(0, 3),
                  $urandom_range(0, 19) == 0);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/grid_mem_arbiter.md
Name: grid_mem_arbiter

Overview:
Shares the single-port snake grid RAM between the VGA renderer and the game engine. It converts VGA pixel coordinates into cell reads during active video. It grants the game engine exclusive RAM access only during vertical blanking, and it generates the game-step tick every STEP_FRAMES frames. The block sits between vga (timing source), the game logic, and the grid RAM.

Parameters:
CELL_SHIFT, 4, log2 of cell size in pixels (16x16 cells)
GRID_W, 40, cells per row
GRID_H, 30, cells per column
ADDR_W, 11, grid RAM address width
DATA_W, 2, bits per cell
V_ACTIVE, 480, first r_pixel value of vertical blanking
STEP_FRAMES, 8, frames per game step (>=1)

Ports:
clk  in  1  system clock (pixel clock domain)
rst  in  1  synchronous, active-high reset
r_pixel  in  10  current row from vga
c_pixel  in  10  current column from vga
video_on  in  1  active-video flag from vga
game_req  in  1  game engine requests RAM
game_en  in  1  access strobe, valid only while game_gnt=1
game_we  in  1  1=write, 0=read
game_addr  in  ADDR_W  game access address
game_wdata  in  DATA_W  game write data
game_done  in  1  single-cycle pulse: game releases RAM
game_gnt  out  1  RAM granted to game
game_rdata  out  DATA_W  read data, valid with game_rvalid
game_rvalid  out  1  read data strobe
step_tick  out  1  single-cycle pulse: advance game one step
overrun_err  out  1  sticky: game held RAM past blanking
mem_addr  out  ADDR_W  RAM address (registered)
mem_we  out  1  RAM write enable (registered)
mem_wdata  out  DATA_W  RAM write data (registered)
mem_rdata  in  DATA_W  RAM read data, 1-cycle latency after mem_addr
pix_cell  out  DATA_W  cell value for current pixel
pix_valid  out  1  pix_cell valid (video_on delayed 2 cycles)

Behaviour:
- Reset: every output is 0. State is RENDER, frame_cnt=0, vblank_q=0.
- vblank = (r_pixel >= V_ACTIVE). The registered vblank_q gives vblank_start = vblank & ~vblank_q.
- Frame counter: increments on vblank_start and wraps at STEP_FRAMES-1. step_tick=1 for one cycle, one cycle after the vblank_start where frame_cnt==STEP_FRAMES-1.
- Render address = (r_pixel>>CELL_SHIFT)*GRID_W + (c_pixel>>CELL_SHIFT). The constant multiply is done as shift-add and the result is ADDR_W wide, max 1199. When video_on=0, the render address is 0.
- Pipeline: coordinates at cycle t give mem_addr at t+1 and mem_rdata at t+2. pix_cell is registered at t+2 and pix_valid equals video_on from cycle t. While in GAME, pix_cell is 0.
- FSM states are RENDER and GAME.
- RENDER -> GAME when vblank & game_req & ~rst. game_gnt=1 from the next cycle.
- GAME -> RENDER on game_done, on ~game_req, or on ~vblank (overrun). game_gnt drops the next cycle.
- An overrun exit sets overrun_err, which is cleared only by rst.
- In GAME, any game access with game_en=1 at cycle t drives mem_addr/mem_we/mem_wdata at t+1. For reads, game_rvalid=1 and game_rdata=mem_rdata at t+2.
- Accesses without game_en, or presented while game_gnt=0, are ignored: mem_we=0.
- A game_done in the same cycle as game_en still completes that access.
- game_req outside vblank is held off. game_gnt stays 0 until vblank.
- Reset mid-GAME: game_gnt=0 and mem_we=0 on the cycle after rst, and any in-flight rvalid is squashed.

Decomposition:
- Package snake_pkg holds:
  - Cell encoding: EMPTY=0, SNAKE=1, FOOD=2, WALL=3.
  - GRID_W, GRID_H, CELL_SHIFT, H_ACTIVE=640, V_ACTIVE=480.
  - The state enum {RENDER, GAME}.
- Sub-module frame_step_timer holds the vblank edge detector, the frame counter and step_tick.

Test Plan:
1. rst high for 3 clk, with game_req=1 and vblank -> all outputs 0, and game_gnt stays 0 during reset.
2. r_pixel=35, c_pixel=100, video_on=1 -> mem_addr=86 one cycle later. With mem_rdata=2: pix_cell=2 and pix_valid=1 two cycles after.
3. STEP_FRAMES=8, drive 8 frames (r_pixel 0..524) -> exactly one step_tick pulse, after the 8th vblank_start, and none on frames 1-7.
4. r_pixel=490, game_req=1 -> game_gnt=1 next cycle. Then write addr 1199 data 1 -> mem_we=1, mem_addr=1199, mem_wdata=1 one cycle later. A read of addr 5 with mem_rdata=3 gives game_rvalid=1 and game_rdata=3 two cycles after.
5. Hold game_req through r_pixel 524->0 -> game_gnt=0 one cycle after vblank falls, overrun_err=1 and stays 1, and a write presented that cycle does not assert mem_we.
6. game_req=1 at r_pixel=100 -> game_gnt stays 0 until r_pixel reaches 480, then rises next cycle. game_done pulse -> game_gnt=0 next cycle and overrun_err remains 0.
